// File: rtl/rcap_gdec_pkg.sv
// Shared types and helpers for the read-capture gray sample-address decoder.
package rcap_gdec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [3:0] ERR_MAX = 4'hF;

  // A clear UPSIE inverts the MSB before the standard reflected-gray decode.
  function automatic logic [2:0] gray3_dec(input logic [2:0] i_g, input logic i_upsie);
    logic [2:0] g;
    g = i_g ^ {~i_upsie, 2'b00};
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/rcap_gdec_gdec3.sv
// Combinational polarity-corrected 3-bit gray-to-binary decode.
module gdec3
  import rcap_gdec_pkg::*;
(
  input  logic [2:0] i_g,
  input  logic       i_upsie,
  output logic [2:0] o_bin
);
  assign o_bin = gray3_dec(i_g, i_upsie);
endmodule

// File: rtl/rcap_gdec_vote.sv
// Bitwise 2-of-3 majority voter.
module vote #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_y
);
  assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/rcap_gdec.sv
// Read-capture sample-address decoder and sequence checker with optional TMR of
// the state, index counters and error counters.
module rcap_gdec
  import rcap_gdec_pkg::*;
#(
  parameter int unsigned NSAMP = 8,
  parameter bit          TMR   = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       UPSIE,
  input  logic [2:0] SAMP,
  input  logic       SAMP_VLD,
  output logic [2:0] BIN,
  output logic       BIN_VLD,
  output logic       SEQ_ERR,
  output logic [3:0] ERR_CNT,
  output logic [7:0] SCNT,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned NR       = TMR ? 3 : 1;
  localparam logic [7:0]  LP_NSAMP = 8'(NSAMP);

  logic [NR-1:0][2:0] w_su_rep;
  logic [NR-1:0][2:0] w_exp_rep;
  logic [NR-1:0][2:0] w_dec_rep;
  logic [NR-1:0][7:0] w_scnt_rep;
  logic [NR-1:0][3:0] w_err_rep;

  logic [2:0] w_su;
  logic [2:0] w_exp;
  logic [2:0] w_bin;
  logic [7:0] w_scnt;
  logic [3:0] w_err;
  state_t     w_state;
  logic       w_upsie;
  logic       w_accept;

  assign w_state  = state_t'(w_su[2:1]);
  assign w_upsie  = w_su[0];
  assign w_accept = (w_state == ST_RUN) && SAMP_VLD && !START;

  // Each replica advances from the voted state, so a single upset is scrubbed next edge.
  for (genvar r = 0; r < NR; r++) begin : g_rep
    state_t     r_state;
    logic       r_upsie;
    logic [2:0] r_exp;
    logic [7:0] r_scnt;
    logic [3:0] r_err;

    gdec3 u_gdec3 (
      .i_g     (SAMP),
      .i_upsie (w_upsie),
      .o_bin   (w_dec_rep[r])
    );

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_state <= ST_IDLE;
        r_upsie <= 1'b1;
        r_exp   <= '0;
        r_scnt  <= '0;
        r_err   <= '0;
      end else if (START) begin
        r_state <= ST_RUN;
        r_upsie <= UPSIE;
        r_exp   <= '0;
        r_scnt  <= '0;
        r_err   <= '0;
      end else if (w_accept) begin
        r_state <= (w_scnt + 8'd1 == LP_NSAMP) ? ST_FIN : ST_RUN;
        r_upsie <= w_upsie;
        r_exp   <= w_exp + 3'd1;
        r_scnt  <= w_scnt + 8'd1;
        r_err   <= (w_dec_rep[r] != w_exp && w_err != ERR_MAX) ? w_err + 4'd1 : w_err;
      end else begin
        r_state <= w_state;
        r_upsie <= w_upsie;
        r_exp   <= w_exp;
        r_scnt  <= w_scnt;
        r_err   <= w_err;
      end
    end

    assign w_su_rep[r]   = {r_state, r_upsie};
    assign w_exp_rep[r]  = r_exp;
    assign w_scnt_rep[r] = r_scnt;
    assign w_err_rep[r]  = r_err;
  end

  if (TMR) begin : g_vote
    vote #(.W(3)) u_v_su   (.i_a(w_su_rep[0]),   .i_b(w_su_rep[1]),   .i_c(w_su_rep[2]),   .o_y(w_su));
    vote #(.W(3)) u_v_exp  (.i_a(w_exp_rep[0]),  .i_b(w_exp_rep[1]),  .i_c(w_exp_rep[2]),  .o_y(w_exp));
    vote #(.W(3)) u_v_dec  (.i_a(w_dec_rep[0]),  .i_b(w_dec_rep[1]),  .i_c(w_dec_rep[2]),  .o_y(w_bin));
    vote #(.W(8)) u_v_scnt (.i_a(w_scnt_rep[0]), .i_b(w_scnt_rep[1]), .i_c(w_scnt_rep[2]), .o_y(w_scnt));
    vote #(.W(4)) u_v_err  (.i_a(w_err_rep[0]),  .i_b(w_err_rep[1]),  .i_c(w_err_rep[2]),  .o_y(w_err));
  end else begin : g_single
    assign w_su   = w_su_rep[0];
    assign w_exp  = w_exp_rep[0];
    assign w_bin  = w_dec_rep[0];
    assign w_scnt = w_scnt_rep[0];
    assign w_err  = w_err_rep[0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BIN     <= '0;
      BIN_VLD <= 1'b0;
    end else begin
      BIN_VLD <= w_accept;
      if (w_accept) BIN <= w_bin;
    end
  end

  // Status flags are pure decodes of registered state; the error flag is sticky
  // because the saturating counter never returns to zero within a run.
  assign ERR_CNT = w_err;
  assign SCNT    = w_scnt;
  assign SEQ_ERR = (w_err != 4'd0);
  assign BUSY    = (w_state == ST_RUN);
  assign DONE    = (w_state == ST_FIN);

endmodule

// File: tb/tb_rcap_gdec.sv
// Self-checking bench for rcap_gdec: an 8-sample plain build and a 20-sample TMR build share stimulus.
module tb_rcap_gdec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       upsie = 1'b1;
  logic [2:0] samp = '0;
  logic       samp_vld = 1'b0;

  logic [2:0] a_bin, b_bin;
  logic       a_bvld, b_bvld, a_serr, b_serr, a_busy, b_busy, a_done, b_done;
  logic [3:0] a_err, b_err;
  logic [7:0] a_scnt, b_scnt;

  always #5 clk = ~clk;

  rcap_gdec #(.NSAMP(8), .TMR(1'b0)) u_dut8 (
    .CLK(clk), .RST(rst), .START(start), .UPSIE(upsie), .SAMP(samp), .SAMP_VLD(samp_vld),
    .BIN(a_bin), .BIN_VLD(a_bvld), .SEQ_ERR(a_serr), .ERR_CNT(a_err), .SCNT(a_scnt),
    .BUSY(a_busy), .DONE(a_done)
  );

  rcap_gdec #(.NSAMP(20), .TMR(1'b1)) u_dut20 (
    .CLK(clk), .RST(rst), .START(start), .UPSIE(upsie), .SAMP(samp), .SAMP_VLD(samp_vld),
    .BIN(b_bin), .BIN_VLD(b_bvld), .SEQ_ERR(b_serr), .ERR_CNT(b_err), .SCNT(b_scnt),
    .BUSY(b_busy), .DONE(b_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: index 0 is the 8-sample build, index 1 the 20-sample build.
  int ns[2] = '{8, 20};
  int m_busy[2], m_done[2], m_up[2], m_exp[2], m_scnt[2], m_err[2], m_serr[2], m_bin[2], m_bvld[2];

  // Decode by position in the published gray sequence for each polarity.
  function automatic int ref_dec(input int s, input int up);
    int seq1[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int seq0[8] = '{4, 5, 7, 6, 2, 3, 1, 0};
    for (int i = 0; i < 8; i++)
      if ((up != 0 ? seq1[i] : seq0[i]) == s) return i;
    return -1;
  endfunction

  function automatic int ref_gray(input int idx, input int up);
    int seq1[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int seq0[8] = '{4, 5, 7, 6, 2, 3, 1, 0};
    return (up != 0) ? seq1[idx] : seq0[idx];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_done[m] = 0; m_up[m] = 1; m_exp[m] = 0; m_scnt[m] = 0;
      m_err[m] = 0; m_serr[m] = 0; m_bin[m] = 0; m_bvld[m] = 0;
    end
  endtask

  task automatic model_step(input int st, input int up, input int s, input int vld);
    int d;
    for (int m = 0; m < 2; m++) begin
      m_bvld[m] = 0;
      if (st != 0) begin
        m_busy[m] = 1; m_done[m] = 0; m_up[m] = up; m_exp[m] = 0;
        m_scnt[m] = 0; m_err[m] = 0; m_serr[m] = 0;
      end else if (m_busy[m] != 0 && vld != 0) begin
        d = ref_dec(s, m_up[m]);
        m_bin[m] = d; m_bvld[m] = 1;
        if (d != m_exp[m]) begin
          m_serr[m] = 1;
          if (m_err[m] < 15) m_err[m]++;
        end
        m_exp[m] = (m_exp[m] + 1) % 8;
        m_scnt[m]++;
        if (m_scnt[m] == ns[m]) begin m_busy[m] = 0; m_done[m] = 1; end
      end
    end
  endtask

  task automatic check_all();
    chk("a_bin",  int'(a_bin),  m_bin[0]);   chk("b_bin",  int'(b_bin),  m_bin[1]);
    chk("a_bvld", int'(a_bvld), m_bvld[0]);  chk("b_bvld", int'(b_bvld), m_bvld[1]);
    chk("a_serr", int'(a_serr), m_serr[0]);  chk("b_serr", int'(b_serr), m_serr[1]);
    chk("a_err",  int'(a_err),  m_err[0]);   chk("b_err",  int'(b_err),  m_err[1]);
    chk("a_scnt", int'(a_scnt), m_scnt[0]);  chk("b_scnt", int'(b_scnt), m_scnt[1]);
    chk("a_busy", int'(a_busy), m_busy[0]);  chk("b_busy", int'(b_busy), m_busy[1]);
    chk("a_done", int'(a_done), m_done[0]);  chk("b_done", int'(b_done), m_done[1]);
  endtask

  task automatic cyc(input int st, input int up, input int s, input int vld);
    start = (st != 0); upsie = (up != 0); samp = 3'(s); samp_vld = (vld != 0);
    if (rst) model_reset();
    else model_step(st, up, s, vld);
    @(posedge clk); #1;
    check_all();
  endtask

  typedef struct {
    int st, up, samp, vld;
    int bin, bvld, serr, err, scnt, busy, done;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // Clean UPSIE=1 run, then the single-error run (third sample 010).
    tbl[0]  = '{1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{0, 1, 0, 1,  0, 1, 0, 0, 1, 1, 0};
    tbl[2]  = '{0, 1, 1, 1,  1, 1, 0, 0, 2, 1, 0};
    tbl[3]  = '{0, 1, 3, 1,  2, 1, 0, 0, 3, 1, 0};
    tbl[4]  = '{0, 1, 2, 1,  3, 1, 0, 0, 4, 1, 0};
    tbl[5]  = '{0, 1, 6, 1,  4, 1, 0, 0, 5, 1, 0};
    tbl[6]  = '{0, 1, 7, 1,  5, 1, 0, 0, 6, 1, 0};
    tbl[7]  = '{0, 1, 5, 1,  6, 1, 0, 0, 7, 1, 0};
    tbl[8]  = '{0, 1, 4, 1,  7, 1, 0, 0, 8, 0, 1};
    tbl[9]  = '{1, 1, 0, 0,  7, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{0, 1, 0, 1,  0, 1, 0, 0, 1, 1, 0};
    tbl[11] = '{0, 1, 1, 1,  1, 1, 0, 0, 2, 1, 0};
    tbl[12] = '{0, 1, 2, 1,  3, 1, 1, 1, 3, 1, 0};
    tbl[13] = '{0, 1, 2, 1,  3, 1, 1, 1, 4, 1, 0};
    tbl[14] = '{0, 1, 6, 1,  4, 1, 1, 1, 5, 1, 0};
    tbl[15] = '{0, 1, 7, 1,  5, 1, 1, 1, 6, 1, 0};
    tbl[16] = '{0, 1, 5, 1,  6, 1, 1, 1, 7, 1, 0};
    tbl[17] = '{0, 1, 4, 1,  7, 1, 1, 1, 8, 0, 1};

    model_reset();
    rst = 1'b1;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    chk("rst_bin", int'(a_bin), 0);
    chk("rst_busy", int'(b_busy), 0);
    #1 rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].st, tbl[i].up, tbl[i].samp, tbl[i].vld);
      chk("tbl_bin",  int'(a_bin),  tbl[i].bin);
      chk("tbl_bvld", int'(a_bvld), tbl[i].bvld);
      chk("tbl_serr", int'(a_serr), tbl[i].serr);
      chk("tbl_err",  int'(a_err),  tbl[i].err);
      chk("tbl_scnt", int'(a_scnt), tbl[i].scnt);
      chk("tbl_busy", int'(a_busy), tbl[i].busy);
      chk("tbl_done", int'(a_done), tbl[i].done);
    end

    // UPSIE=0 run with UPSIE toggling mid-run.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, int'($urandom_range(0, 1)), ref_gray(i, 0), 1);
      chk("up0_bin", int'(a_bin), i);
    end
    chk("up0_err", int'(a_err), 0);
    chk("up0_done", int'(a_done), 1);

    // All samples wrong on the 8-sample build; wrap and saturation on the 20-sample build.
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 1);
    chk("all0_err8", int'(a_err), 7);
    chk("sat_err20", int'(b_err), 15);
    chk("sat_serr20", int'(b_serr), 1);
    chk("sat_scnt20", int'(b_scnt), 20);
    chk("sat_done20", int'(b_done), 1);

    // START together with SAMP_VLD mid-run.
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, ref_gray(i, 1), 1);
    cyc(1, 1, 3, 1);
    chk("rs_bvld", int'(a_bvld), 0);
    chk("rs_scnt", int'(a_scnt), 0);
    cyc(0, 1, 0, 1);
    chk("rs_bin0", int'(a_bin), 0);
    chk("rs_err", int'(a_err), 0);
    for (int i = 1; i < 8; i++) cyc(0, 1, ref_gray(i, 1), 1);
    chk("rs_done", int'(a_done), 1);
    cyc(0, 1, 0, 1);
    chk("fin_bvld", int'(a_bvld), 0);
    chk("fin_scnt", int'(a_scnt), 8);

    // Asynchronous reset after four samples.
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, ref_gray(i, 1), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_bin", int'(a_bin), 0);   chk("arst_bvld", int'(a_bvld), 0);
    chk("arst_scnt", int'(a_scnt), 0); chk("arst_busy", int'(a_busy), 0);
    chk("arst_done", int'(a_done), 0); chk("arst_bscnt", int'(b_scnt), 0);
    chk("arst_bbusy", int'(b_busy), 0);
    cyc(0, 1, 0, 1);
    rst = 1'b0;
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, ref_gray(i, 1), 1);
    chk("post_done", int'(a_done), 1);
    chk("post_err", int'(a_err), 0);

    // Randomized traffic, biased towards the expected gray code.
    for (int n = 0; n < 600; n++) begin
      int st, up, s, vld;
      st  = ($urandom_range(0, 24) == 0) ? 1 : 0;
      up  = int'($urandom_range(0, 1));
      vld = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s   = ($urandom_range(0, 2) != 0) ? ref_gray(m_exp[0], m_up[0]) : int'($urandom_range(0, 7));
      cyc(st, up, s, vld);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
